// File: rtl/irq_ack_dispatch_pkg.sv
// Shared definitions for the KCPSM3 interrupt acknowledge dispatcher.
package irq_ack_dispatch_pkg;

    // vector value reported when no source was serviced (spurious acknowledge)
    localparam logic [2:0] VEC_NONE = 3'b111;

    // width of the acknowledge pulse counter
    localparam int CNT_W = 4;

    // dispatcher FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
import irq_ack_dispatch_pkg::*;

module irq_prio_enc #(
    parameter int NUM_SRC = 5
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               found,
    output logic [2:0]         idx
);

    // scan from the highest index down so the lowest set index is the last one written
    always_comb begin
        found = 1'b0;
        idx   = VEC_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = 3'(i);
            end else begin
                found = found;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/irq_ack_dispatch.sv
// Interrupt acknowledge dispatcher for the KCPSM3 core: captures per-source request
// edges, raises INTERRUPT, and on INTERRUPT_ACK sends one active-low ack pulse to the
// highest-priority (lowest index) enabled pending source.
import irq_ack_dispatch_pkg::*;

module irq_ack_dispatch #(
    parameter int NUM_SRC = 5,
    parameter int ACK_LEN = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_n,
    input  logic [NUM_SRC-1:0] irq_en,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic [NUM_SRC-1:0] ack_n,
    output logic [2:0]         vector,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // one-hot mask selecting source idx
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [2:0] idx);
        logic [NUM_SRC-1:0] oh;
        for (int i = 0; i < NUM_SRC; i++) begin
            oh[i] = (idx == 3'(i));
        end
        return oh;
    endfunction

    irq_state_e         state_r, state_nxt_s;
    logic [NUM_SRC-1:0] irq_q_r;
    logic               armed_r;
    logic [NUM_SRC-1:0] pend_r, pend_nxt_s;
    logic [NUM_SRC-1:0] edge_s, clr_mask_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               int_r, int_nxt_s;
    logic [NUM_SRC-1:0] ack_n_r, ack_n_nxt_s;
    logic [2:0]         vector_r, vector_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               found_s;
    logic [2:0]         win_idx_s;

    // Edge detect is suppressed for the first cycle out of reset so that a line
    // held low through reset is not mistaken for a new request.
    assign edge_s = irq_q_r & ~irq_n & {NUM_SRC{armed_r}};

    // a new request edge beats a clear of the same bit in the same cycle
    assign pend_nxt_s = (pend_r & ~clr_mask_s) | edge_s;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (pend_r & irq_en),
        .found (found_s),
        .idx   (win_idx_s)
    );

    // input stage: request line history and post-reset arming flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q_r <= {NUM_SRC{1'b1}};
            armed_r <= 1'b0;
        end else begin
            irq_q_r <= irq_n;
            armed_r <= 1'b1;
        end
    end

    // FSM next state, winner selection and next values of the output registers
    always_comb begin
        state_nxt_s  = state_r;
        clr_mask_s   = {NUM_SRC{1'b0}};
        cnt_nxt_s    = cnt_r;
        ack_n_nxt_s  = ack_n_r;
        vector_nxt_s = vector_r;
        busy_nxt_s   = busy_r;
        int_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                int_nxt_s = |(pend_r & irq_en);
                if (interrupt_ack) begin
                    if (found_s) begin
                        clr_mask_s   = src_onehot(win_idx_s);
                        vector_nxt_s = win_idx_s;
                        ack_n_nxt_s  = ~src_onehot(win_idx_s);
                        cnt_nxt_s    = CNT_LOAD;
                        busy_nxt_s   = 1'b1;
                        int_nxt_s    = 1'b0;
                        state_nxt_s  = ST_ACK;
                    end else begin
                        vector_nxt_s = VEC_NONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (cnt_r == CNT_ZERO) begin
                    ack_n_nxt_s = {NUM_SRC{1'b1}};
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                ack_n_nxt_s = {NUM_SRC{1'b1}};
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // state, pending, counter and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            pend_r   <= {NUM_SRC{1'b0}};
            cnt_r    <= CNT_ZERO;
            int_r    <= 1'b0;
            ack_n_r  <= {NUM_SRC{1'b1}};
            vector_r <= VEC_NONE;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pend_r   <= pend_nxt_s;
            cnt_r    <= cnt_nxt_s;
            int_r    <= int_nxt_s;
            ack_n_r  <= ack_n_nxt_s;
            vector_r <= vector_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign interrupt = int_r;
    assign ack_n     = ack_n_r;
    assign vector    = vector_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_irq_ack_dispatch.sv
// Directed bench for irq_ack_dispatch (NUM_SRC=5, ACK_LEN=2).
module tb_irq_ack_dispatch;

    logic       clk;
    logic       reset_n;
    logic [4:0] irq_n;
    logic [4:0] irq_en;
    logic       interrupt;
    logic       interrupt_ack;
    logic [4:0] ack_n;
    logic [2:0] vector;
    logic       busy;

    int vecs;
    int errs;

    irq_ack_dispatch #(
        .NUM_SRC (5),
        .ACK_LEN (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .irq_n         (irq_n),
        .irq_en        (irq_en),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .ack_n         (ack_n),
        .vector        (vector),
        .busy          (busy)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to the next falling edge: inputs are driven and outputs sampled there
    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic chk_int(input string name, input logic exp);
        vecs++;
        if (interrupt !== exp) begin
            errs++;
            $display("FAIL %s: interrupt got %b want %b", name, interrupt, exp);
        end
    endtask

    task automatic chk_ack(input string name, input logic [4:0] exp_ack, input logic [2:0] exp_vec, input logic exp_busy);
        vecs++;
        if (ack_n !== exp_ack || vector !== exp_vec || busy !== exp_busy) begin
            errs++;
            $display("FAIL %s: ack_n/vector/busy got %b/%0d/%b want %b/%0d/%b",
                     name, ack_n, vector, busy, exp_ack, exp_vec, exp_busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; irq_n = 5'b11111; irq_en = 5'b11111; interrupt_ack = 1'b0;
        step(2);
        chk_int("reset_int", 1'b0);
        chk_ack("reset_outs", 5'b11111, 3'b111, 1'b0);
        reset_n = 1'b1;
        step(2);
        chk_int("post_reset_int", 1'b0);
    endtask

    task automatic test_single();
        irq_n = 5'b11011;
        step(1);
        chk_int("single_int_t1", 1'b0);
        step(1);
        chk_int("single_int_t2", 1'b1);
        interrupt_ack = 1'b1;
        step(1);
        interrupt_ack = 1'b0;
        chk_ack("single_ack_c1", 5'b11011, 3'd2, 1'b1);
        chk_int("single_int_drop", 1'b0);
        step(1);
        chk_ack("single_ack_c2", 5'b11011, 3'd2, 1'b1);
        step(1);
        chk_ack("single_release", 5'b11111, 3'd2, 1'b0);
        step(1);
        chk_int("single_pending_cleared", 1'b0);
        irq_n = 5'b11111;
        step(1);
    endtask

    task automatic test_priority();
        irq_n = 5'b01101;
        step(2);
        chk_int("prio_int", 1'b1);
        interrupt_ack = 1'b1;
        step(1);
        interrupt_ack = 1'b0;
        chk_ack("prio_first", 5'b11101, 3'd1, 1'b1);
        step(2);
        chk_ack("prio_first_release", 5'b11111, 3'd1, 1'b0);
        chk_int("prio_int_at_release", 1'b0);
        step(1);
        chk_int("prio_int_reassert", 1'b1);
        interrupt_ack = 1'b1;
        step(1);
        interrupt_ack = 1'b0;
        chk_ack("prio_second", 5'b01111, 3'd4, 1'b1);
        step(2);
        chk_ack("prio_second_release", 5'b11111, 3'd4, 1'b0);
        irq_n = 5'b11111;
        step(1);
        chk_int("prio_all_served", 1'b0);
    endtask

    task automatic test_mask();
        irq_en = 5'b11110;
        irq_n  = 5'b11110;
        step(3);
        chk_int("mask_blocked", 1'b0);
        irq_en = 5'b11111;
        step(1);
        chk_int("mask_unblocked", 1'b1);
        interrupt_ack = 1'b1;
        step(1);
        interrupt_ack = 1'b0;
        chk_ack("mask_ack", 5'b11110, 3'd0, 1'b1);
        step(2);
        chk_ack("mask_release", 5'b11111, 3'd0, 1'b0);
        irq_n = 5'b11111;
        step(1);
    endtask

    task automatic test_spurious();
        chk_int("spur_idle", 1'b0);
        interrupt_ack = 1'b1;
        step(1);
        interrupt_ack = 1'b0;
        chk_ack("spur_ack", 5'b11111, 3'b111, 1'b0);
        step(1);
        chk_ack("spur_hold", 5'b11111, 3'b111, 1'b0);
    endtask

    task automatic test_collision();
        irq_n = 5'b10111;
        step(2);
        chk_int("coll_int", 1'b1);
        irq_n = 5'b11111;
        step(1);
        // re-fall of source 3 lands in the same cycle its pending bit is cleared
        irq_n = 5'b10111;
        interrupt_ack = 1'b1;
        step(1);
        chk_ack("coll_first", 5'b10111, 3'd3, 1'b1);
        // acknowledge while the pulse is in progress must be ignored
        step(1);
        interrupt_ack = 1'b0;
        chk_ack("coll_ack_ignored", 5'b10111, 3'd3, 1'b1);
        step(1);
        chk_ack("coll_release", 5'b11111, 3'd3, 1'b0);
        step(1);
        chk_int("coll_pending_kept", 1'b1);
        interrupt_ack = 1'b1;
        step(1);
        interrupt_ack = 1'b0;
        chk_ack("coll_second", 5'b10111, 3'd3, 1'b1);
        step(2);
        chk_ack("coll_second_release", 5'b11111, 3'd3, 1'b0);
        step(1);
        chk_int("coll_drained", 1'b0);
    endtask

    task automatic test_reset_mid_pulse();
        // source 3 stays held low from the previous test; only source 1 makes a new edge
        irq_n = 5'b10101;
        step(2);
        chk_int("rst_int", 1'b1);
        interrupt_ack = 1'b1;
        step(1);
        interrupt_ack = 1'b0;
        chk_ack("rst_ack_c1", 5'b11101, 3'd1, 1'b1);
        step(1);
        chk_ack("rst_ack_c2", 5'b11101, 3'd1, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk_ack("rst_async", 5'b11111, 3'b111, 1'b0);
        chk_int("rst_async_int", 1'b0);
        step(2);
        reset_n = 1'b1;
        step(4);
        chk_int("rst_held_low_ignored", 1'b0);
        chk_ack("rst_held_outs", 5'b11111, 3'b111, 1'b0);
        irq_n = 5'b11111;
        step(1);
        irq_n = 5'b11101;
        step(2);
        chk_int("rst_rearm", 1'b1);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_spurious();
        test_collision();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
